// File: rtl/store_lane_unit_if.sv
// Store request and memory write-port signals; slave = store unit view, master = requester/memory view.
interface store_lane_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [XLEN-1:0]   req_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;

  modport slave (
    input  req_valid, req_addr, req_size, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_size, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/store_lane_unit.sv
// Lane-positions a store onto the bus, splitting word-crossing stores into two beats; done 2 (1 beat) / 3 (2 beats) cycles after accept.
// Beats held stable until mem_ready; req_ready only in IDLE, so one store is in flight at a time.
module store_lane_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  store_lane_unit_if.slave  bus,
  output logic              done,
  output logic              err
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;
  logic [NB-1:0]     hi_be_q, hi_be_d;
  logic [XLEN-1:0]   hi_wdata_q, hi_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [OFF_W-1:0]  off;
  logic [ADDR_W-1:0] base_addr;
  logic [2*NB-1:0]   lane_base, lane_mask;
  logic [2*XLEN-1:0] data_base, data_pos;
  logic              size_ok, illegal;

  // Request decode: mask and data are built double-width so the spill into the next word falls out of one shift.
  always_comb begin
    off       = bus.req_addr[OFF_W-1:0];
    base_addr = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    case (bus.req_size)
      2'd0:    lane_base = (2*NB)'(8'h01);
      2'd1:    lane_base = (2*NB)'(8'h03);
      2'd2:    lane_base = (2*NB)'(8'h0F);
      default: lane_base = (2*NB)'(8'hFF);
    endcase
    data_base = '0;
    for (int i = 0; i < NB; i++) begin
      data_base[8*i +: 8] = bus.req_data[8*i +: 8] & {8{lane_base[i]}};
    end
    lane_mask = lane_base << off;
    data_pos  = data_base << {off, 3'b000};
    size_ok   = ({1'b0, bus.req_size} <= 3'(OFF_W));
    illegal   = !size_ok || (!MISALIGN_SPLIT && (lane_mask[2*NB-1:NB] != '0));
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    hi_addr_d   = hi_addr_q;
    hi_be_d     = hi_be_q;
    hi_wdata_d  = hi_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = base_addr;
            mem_be_d    = lane_mask[NB-1:0];
            mem_wdata_d = data_pos[XLEN-1:0];
            hi_addr_d   = base_addr + ADDR_W'(NB);
            hi_be_d     = lane_mask[2*NB-1:NB];
            hi_wdata_d  = data_pos[2*XLEN-1:XLEN];
          end
        end
      end
      BEAT0: begin
        if (bus.mem_ready) begin
          if (hi_be_q == '0) begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            // Second beat follows directly with no idle cycle between.
            state_d     = BEAT1;
            mem_addr_d  = hi_addr_q;
            mem_be_d    = hi_be_q;
            mem_wdata_d = hi_wdata_q;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      hi_addr_q   <= '0;
      hi_be_q     <= '0;
      hi_wdata_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      hi_addr_q   <= hi_addr_d;
      hi_be_q     <= hi_be_d;
      hi_wdata_q  <= hi_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_valid_q ? mem_addr_q  : '0;
  assign bus.mem_be    = mem_valid_q ? mem_be_q    : '0;
  assign bus.mem_wdata = mem_valid_q ? mem_wdata_q : '0;
  assign done          = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_store_lane_unit.sv
// Directed-vector bench: a splitting and a non-splitting store_lane_unit, XLEN=32.
module tb_store_lane_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic s_done, s_err, n_done, n_err;

  store_lane_unit_if #(.XLEN(32), .ADDR_W(32)) s_if ();
  store_lane_unit_if #(.XLEN(32), .ADDR_W(32)) n_if ();

  store_lane_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u_split (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave), .done(s_done), .err(s_err)
  );
  store_lane_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u_nosplit (
    .clk(clk), .rst_n(rst_n), .bus(n_if.slave), .done(n_done), .err(n_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  int s_done_cnt = 0;
  int n_mv_cnt = 0;
  int c0;

  always @(negedge clk) begin
    if (s_done) s_done_cnt++;
    if (n_if.mem_valid) n_mv_cnt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    s_if.req_valid = 1'b1;
    s_if.req_addr  = a;
    s_if.req_size  = sz;
    s_if.req_data  = d;
    step;
    s_if.req_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    chk({tag, "_vld"},   s_if.mem_valid, 1'b1);
    chk({tag, "_addr"},  s_if.mem_addr,  a);
    chk({tag, "_be"},    s_if.mem_be,    be);
    chk({tag, "_wdata"}, s_if.mem_wdata, wd);
  endtask

  task automatic n_issue(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    n_if.req_valid = 1'b1;
    n_if.req_addr  = a;
    n_if.req_size  = sz;
    n_if.req_data  = d;
    step;
    n_if.req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    s_if.req_valid = 1'b0; s_if.req_addr = '0; s_if.req_size = '0; s_if.req_data = '0; s_if.mem_ready = 1'b1;
    n_if.req_valid = 1'b0; n_if.req_addr = '0; n_if.req_size = '0; n_if.req_data = '0; n_if.mem_ready = 1'b1;
    step;
    step;
    chk("rst_mem_valid", s_if.mem_valid, 1'b0);
    chk("rst_mem_addr",  s_if.mem_addr,  32'h0);
    chk("rst_mem_be",    s_if.mem_be,    4'h0);
    chk("rst_mem_wdata", s_if.mem_wdata, 32'h0);
    chk("rst_done",      s_done,         1'b0);
    chk("rst_err",       s_err,          1'b0);
    rst_n = 1'b1;
    step;
    chk("rst_req_ready", s_if.req_ready, 1'b1);

    // SB at 0x103
    issue(32'h103, 2'd0, 32'hAABBCCDD);
    beat("sb", 32'h100, 4'b1000, 32'hDD000000);
    chk("sb_done_early", s_done, 1'b0);
    step;
    chk("sb_done",      s_done,         1'b1);
    chk("sb_idle_vld",  s_if.mem_valid, 1'b0);
    chk("sb_idle_be",   s_if.mem_be,    4'h0);
    chk("sb_idle_wd",   s_if.mem_wdata, 32'h0);
    chk("sb_req_ready", s_if.req_ready, 1'b1);

    // SH at 0x102, accepted in the same cycle as the previous done
    issue(32'h102, 2'd1, 32'hAABBCCDD);
    beat("sh", 32'h100, 4'b1100, 32'hCCDD0000);
    step;
    chk("sh_done", s_done, 1'b1);
    step;

    // Split SW at 0x102
    issue(32'h102, 2'd2, 32'hAABBCCDD);
    beat("sw0", 32'h100, 4'b1100, 32'hCCDD0000);
    chk("sw0_done", s_done, 1'b0);
    step;
    beat("sw1", 32'h104, 4'b0011, 32'h0000AABB);
    chk("sw1_done",  s_done,         1'b0);
    chk("sw1_ready", s_if.req_ready, 1'b0);
    step;
    chk("sw_done",     s_done,         1'b1);
    chk("sw_idle_vld", s_if.mem_valid, 1'b0);
    step;

    // Same split store with 3-cycle stalls on each beat
    c0 = s_done_cnt;
    s_if.mem_ready = 1'b0;
    issue(32'h102, 2'd2, 32'hAABBCCDD);
    for (int i = 0; i < 3; i++) begin
      beat("stall0", 32'h100, 4'b1100, 32'hCCDD0000);
      chk("stall0_ready", s_if.req_ready, 1'b0);
      step;
    end
    s_if.mem_ready = 1'b1;
    step;
    s_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat("stall1", 32'h104, 4'b0011, 32'h0000AABB);
      chk("stall1_ready", s_if.req_ready, 1'b0);
      step;
    end
    s_if.mem_ready = 1'b1;
    step;
    chk("stall_done", s_done, 1'b1);
    step;
    chk("stall_done_count", s_done_cnt - c0, 1);

    // Illegal size on the splitting unit
    issue(32'h100, 2'd3, 32'hAABBCCDD);
    chk("sz3_err",   s_err,          1'b1);
    chk("sz3_vld",   s_if.mem_valid, 1'b0);
    chk("sz3_ready", s_if.req_ready, 1'b1);
    step;
    chk("sz3_err_pulse", s_err, 1'b0);

    // Non-splitting unit: misaligned crossing SW and size 3 both rejected
    n_issue(32'h101, 2'd2, 32'hAABBCCDD);
    chk("ns_sw_err",  n_err,  1'b1);
    chk("ns_sw_done", n_done, 1'b0);
    step;
    chk("ns_sw_err_pulse", n_err, 1'b0);
    n_issue(32'h100, 2'd3, 32'hAABBCCDD);
    chk("ns_sz3_err", n_err, 1'b1);
    step;
    chk("ns_no_bus", n_mv_cnt, 0);
    n_issue(32'h101, 2'd1, 32'hAABBCCDD);
    chk("ns_sh_err",   n_err,          1'b0);
    chk("ns_sh_vld",   n_if.mem_valid, 1'b1);
    chk("ns_sh_addr",  n_if.mem_addr,  32'h100);
    chk("ns_sh_be",    n_if.mem_be,    4'b0110);
    chk("ns_sh_wdata", n_if.mem_wdata, 32'h00CCDD00);
    step;
    chk("ns_sh_done", n_done, 1'b1);
    step;

    // Reset during BEAT1 drops the beat with no done
    c0 = s_done_cnt;
    issue(32'h102, 2'd2, 32'hAABBCCDD);
    step;
    beat("rb1", 32'h104, 4'b0011, 32'h0000AABB);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_vld",  s_if.mem_valid, 1'b0);
    chk("rst_mid_be",   s_if.mem_be,    4'h0);
    chk("rst_mid_addr", s_if.mem_addr,  32'h0);
    step;
    #2 rst_n = 1'b1;
    step;
    step;
    chk("rst_mid_no_done", s_done_cnt - c0, 0);
    chk("rst_mid_ready",   s_if.req_ready, 1'b1);
    issue(32'h1, 2'd0, 32'h11223344);
    beat("post_rst_sb", 32'h0, 4'b0010, 32'h00004400);
    step;
    chk("post_rst_done", s_done, 1'b1);
    step;

    // Address wrap on the second beat
    issue(32'hFFFFFFFE, 2'd2, 32'hAABBCCDD);
    beat("wrap0", 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000);
    step;
    beat("wrap1", 32'h00000000, 4'b0011, 32'h0000AABB);
    step;
    chk("wrap_done", s_done, 1'b1);
    chk("never_both", s_done & s_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
